agendador_conversor_bcd: RTL and testbench
==========================================

AGENDADOR_CONVERSOR_BCD -- requirements
Module: agendador_conversor_bcd

Interface
REQ-001 SHALL have parameter NUM_CANAIS, default 4: number of requesters sharing one BCD conversion core.
REQ-002 SHALL have parameter LARGURA_ENTRADA, default 16: binary operand width.
REQ-003 SHALL have parameter DIGITOS_DECIMAIS, default 4: BCD result digits.
REQ-004 SHALL have parameter LIMITE_ESPERA, default 255: maximum cycles allowed in AGUARDA before timeout.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port req_valido, input, NUM_CANAIS: per-channel conversion request, held until req_pronto.
REQ-008 SHALL have port req_dados, input, NUM_CANAIS*LARGURA_ENTRADA: channel i operand at bits [i*LARGURA_ENTRADA +: LARGURA_ENTRADA].
REQ-009 SHALL have port req_pronto, output, NUM_CANAIS: one-hot, one-cycle accept pulse.
REQ-010 SHALL have port resp_valido, output, NUM_CANAIS: one-hot, one-cycle result pulse to owning channel.
REQ-011 SHALL have port resp_bcd, output, DIGITOS_DECIMAIS*4: shared result bus, meaningful while any resp_valido bit is high.
REQ-012 SHALL have port resp_erro, output, 1: timeout flag, meaningful with resp_valido.
REQ-013 SHALL have port core_iniciar, output, 1: start pulse to conversion core.
REQ-014 SHALL have port core_entrada, output, LARGURA_ENTRADA: operand to core.
REQ-015 SHALL have port core_saida_bcd, input, DIGITOS_DECIMAIS*4: core result.
REQ-016 SHALL have port core_dados_validos, input, 1: core one-cycle done pulse.
REQ-017 SHALL have port ocupado, output, 1: high whenever state is not OCIOSO.
REQ-018 SHALL have port total_conversoes, output, 16: count of completed responses (valid or error), wraps 0xFFFF->0.

Function
REQ-019 SHALL implement FSM OCIOSO -> INICIA -> AGUARDA -> ENTREGA -> OCIOSO; all outputs registered.
REQ-020 In OCIOSO with req_valido != 0: grant first requesting channel searching from pointer prioridade upward, wrapping NUM_CANAIS-1 -> 0; capture its operand and index; go INICIA.
REQ-021 In OCIOSO with req_valido == 0: remain in OCIOSO, no outputs asserted.
REQ-022 On grant, prioridade SHALL become (granted index + 1) mod NUM_CANAIS.
REQ-023 In INICIA (exactly one cycle): req_pronto[granted]=1, core_iniciar=1, core_entrada=captured operand; next state AGUARDA.
REQ-024 core_entrada SHALL hold the captured operand from INICIA through end of AGUARDA.
REQ-025 req_valido/req_dados SHALL be ignored outside OCIOSO; new arbitration only after ENTREGA.
REQ-026 In AGUARDA: wait counter starts at 0 and increments each cycle; on core_dados_validos=1 latch core_saida_bcd into resp_bcd, resp_erro<=0, go ENTREGA.
REQ-027 In AGUARDA: if counter == LIMITE_ESPERA-1 and core_dados_validos=0, set resp_bcd<=0, resp_erro<=1, go ENTREGA.
REQ-028 core_dados_validos and timeout in the same cycle: valid data wins, resp_erro=0.
REQ-029 core_dados_validos outside AGUARDA SHALL be ignored.
REQ-030 In ENTREGA (exactly one cycle): resp_valido[granted]=1, resp_bcd/resp_erro stable; total_conversoes increments; next state OCIOSO.
REQ-031 Latency: request seen in OCIOSO cycle T -> req_pronto/core_iniciar in T+1; core done pulse in cycle D -> resp_valido in D+1; OCIOSO again in D+2.
REQ-032 resp_bcd and resp_erro SHALL hold their last value until the next ENTREGA.

Reset
REQ-033 When reset=1 at a rising edge, regardless of state (including mid-AGUARDA): state=OCIOSO, prioridade=0, wait counter=0, total_conversoes=0, req_pronto=0, resp_valido=0, resp_bcd=0, resp_erro=0, core_iniciar=0, core_entrada=0, ocupado=0.
REQ-034 The conversion core SHALL be reset from the same source (its reset_n = ~reset), so no stale done pulse survives reset.

Verification
REQ-035 Single channel: req_valido=4'b0001, req_dados[15:0]=16'd1234 -> req_pronto=4'b0001 one cycle, then resp_valido=4'b0001 with resp_bcd=16'h1234, resp_erro=0, total_conversoes=1.
REQ-036 Round robin: all four channels request continuously with operands 1,22,333,4444 -> grants in order 0,1,2,3,0; results 16'h0001,16'h0022,16'h0333,16'h4444.
REQ-037 Wrap: prioridade=3, req_valido=4'b0101 -> channel 0 granted, then channel 2.
REQ-038 Timeout: core model never pulses core_dados_validos -> exactly 255 cycles in AGUARDA, then resp_valido to owner, resp_erro=1, resp_bcd=0.
REQ-039 Simultaneous: core_dados_validos on the 255th AGUARDA cycle with 16'h9999 -> resp_erro=0, resp_bcd=16'h9999.
REQ-040 Reset mid-AGUARDA: assert reset for one cycle -> all outputs 0, prioridade=0; pending channel re-requests and completes normally.

Source files
------------

// File: rtl/agendador_conversor_bcd.sv
// -----------------------------------------------------------------------------
// agendador_conversor_bcd
// Round-robin scheduler that shares one binary-to-BCD conversion core among
// NUM_CANAIS requesters. One request is serviced at a time. Each request
// follows the sequence grant -> core start -> wait for the core (with a
// timeout) -> deliver the result to the owning channel.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   req_valido          per-channel request, held until req_pronto
//   req_dados           packed operands; channel i at [i*LARGURA_ENTRADA +: LARGURA_ENTRADA]
//   req_pronto          one-hot, one-cycle accept pulse
//   resp_valido         one-hot, one-cycle result pulse to the owning channel
//   resp_bcd            shared result bus, held until the next delivery
//   resp_erro           timeout flag, qualified by resp_valido
//   core_iniciar        one-cycle start pulse to the conversion core
//   core_entrada        operand to the core, held while the core is busy
//   core_saida_bcd      core result
//   core_dados_validos  core one-cycle done pulse
//   ocupado             high whenever the scheduler is not idle
//   total_conversoes    count of delivered responses (valid or timeout), wraps
// The external core must be reset from the same source (reset_n = ~reset).
// -----------------------------------------------------------------------------
module agendador_conversor_bcd #(
    parameter int unsigned NUM_CANAIS       = 4,
    parameter int unsigned LARGURA_ENTRADA  = 16,
    parameter int unsigned DIGITOS_DECIMAIS = 4,
    parameter int unsigned LIMITE_ESPERA    = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CANAIS-1:0]                 req_valido,
    input  logic [NUM_CANAIS*LARGURA_ENTRADA-1:0] req_dados,
    output logic [NUM_CANAIS-1:0]                 req_pronto,
    output logic [NUM_CANAIS-1:0]                 resp_valido,
    output logic [DIGITOS_DECIMAIS*4-1:0]         resp_bcd,
    output logic                                  resp_erro,
    output logic                                  core_iniciar,
    output logic [LARGURA_ENTRADA-1:0]            core_entrada,
    input  logic [DIGITOS_DECIMAIS*4-1:0]         core_saida_bcd,
    input  logic                                  core_dados_validos,
    output logic                                  ocupado,
    output logic [15:0]                           total_conversoes
);

    localparam int unsigned LARG_IDX  = (NUM_CANAIS > 1) ? $clog2(NUM_CANAIS) : 1;
    localparam int unsigned LARG_CONT = $clog2(LIMITE_ESPERA + 1);
    localparam int unsigned LARG_BCD  = DIGITOS_DECIMAIS * 4;
    localparam logic [LARG_CONT-1:0] CONT_LIMITE = LARG_CONT'(LIMITE_ESPERA - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        INICIA  = 2'd1,
        AGUARDA = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    estado_t                    estado_q, estado_d;
    logic [LARG_IDX-1:0]        prioridade_q, prioridade_d;
    logic [LARG_IDX-1:0]        canal_q, canal_d;
    logic [LARG_CONT-1:0]       cont_q, cont_d;
    logic [NUM_CANAIS-1:0]      req_pronto_q, req_pronto_d;
    logic [NUM_CANAIS-1:0]      resp_valido_q, resp_valido_d;
    logic [LARG_BCD-1:0]        resp_bcd_q, resp_bcd_d;
    logic                       resp_erro_q, resp_erro_d;
    logic                       core_iniciar_q, core_iniciar_d;
    logic [LARGURA_ENTRADA-1:0] core_entrada_q, core_entrada_d;
    logic                       ocupado_q, ocupado_d;
    logic [15:0]                total_q, total_d;

    // Unpacked view of the packed operand bus
    logic [LARGURA_ENTRADA-1:0] operandos [NUM_CANAIS];

    for (genvar g = 0; g < NUM_CANAIS; g++) begin : g_operandos
        assign operandos[g] = req_dados[g*LARGURA_ENTRADA +: LARGURA_ENTRADA];
    end

    // Round-robin search: first requester at or above the priority pointer
    logic                achou;
    logic [LARG_IDX-1:0] escolhido;
    logic [LARG_IDX-1:0] candidato;

    always_comb begin
        achou     = 1'b0;
        escolhido = '0;
        candidato = '0;
        for (int unsigned k = 0; k < NUM_CANAIS; k++) begin
            candidato = LARG_IDX'((32'(prioridade_q) + k) % NUM_CANAIS);
            if (!achou && req_valido[candidato]) begin
                achou     = 1'b1;
                escolhido = candidato;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        estado_d       = estado_q;
        prioridade_d   = prioridade_q;
        canal_d        = canal_q;
        cont_d         = cont_q;
        req_pronto_d   = '0;
        resp_valido_d  = '0;
        resp_bcd_d     = resp_bcd_q;
        resp_erro_d    = resp_erro_q;
        core_iniciar_d = 1'b0;
        core_entrada_d = core_entrada_q;
        total_d        = total_q;

        unique case (estado_q)
            OCIOSO: begin
                if (achou) begin
                    estado_d       = INICIA;
                    canal_d        = escolhido;
                    prioridade_d   = LARG_IDX'((32'(escolhido) + 1) % NUM_CANAIS);
                    core_entrada_d = operandos[escolhido];
                    // Registered, so these appear during the INICIA cycle
                    req_pronto_d   = NUM_CANAIS'(1) << escolhido;
                    core_iniciar_d = 1'b1;
                end
            end

            INICIA: begin
                estado_d = AGUARDA;
                cont_d   = '0;
            end

            AGUARDA: begin
                // Valid data takes precedence over a timeout in the same cycle
                if (core_dados_validos) begin
                    estado_d      = ENTREGA;
                    resp_bcd_d    = core_saida_bcd;
                    resp_erro_d   = 1'b0;
                    resp_valido_d = NUM_CANAIS'(1) << canal_q;
                    total_d       = total_q + 16'd1;
                end else if (cont_q == CONT_LIMITE) begin
                    estado_d      = ENTREGA;
                    resp_bcd_d    = '0;
                    resp_erro_d   = 1'b1;
                    resp_valido_d = NUM_CANAIS'(1) << canal_q;
                    total_d       = total_q + 16'd1;
                end else begin
                    cont_d = cont_q + LARG_CONT'(1);
                end
            end

            ENTREGA: begin
                estado_d = OCIOSO;
                cont_d   = '0;
            end

            default: estado_d = OCIOSO;
        endcase

        ocupado_d = (estado_d != OCIOSO);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            prioridade_q   <= '0;
            canal_q        <= '0;
            cont_q         <= '0;
            req_pronto_q   <= '0;
            resp_valido_q  <= '0;
            resp_bcd_q     <= '0;
            resp_erro_q    <= 1'b0;
            core_iniciar_q <= 1'b0;
            core_entrada_q <= '0;
            ocupado_q      <= 1'b0;
            total_q        <= '0;
        end else begin
            estado_q       <= estado_d;
            prioridade_q   <= prioridade_d;
            canal_q        <= canal_d;
            cont_q         <= cont_d;
            req_pronto_q   <= req_pronto_d;
            resp_valido_q  <= resp_valido_d;
            resp_bcd_q     <= resp_bcd_d;
            resp_erro_q    <= resp_erro_d;
            core_iniciar_q <= core_iniciar_d;
            core_entrada_q <= core_entrada_d;
            ocupado_q      <= ocupado_d;
            total_q        <= total_d;
        end
    end

    assign req_pronto       = req_pronto_q;
    assign resp_valido      = resp_valido_q;
    assign resp_bcd         = resp_bcd_q;
    assign resp_erro        = resp_erro_q;
    assign core_iniciar     = core_iniciar_q;
    assign core_entrada     = core_entrada_q;
    assign ocupado          = ocupado_q;
    assign total_conversoes = total_q;

endmodule

// File: tb/tb_agendador_conversor_bcd.sv
// -----------------------------------------------------------------------------
// Testbench for agendador_conversor_bcd. A behavioural core model answers each
// start pulse after a chosen delay (or never). The driver pushes expected
// grants and responses into queues. A monitor compares them when the DUT
// presents req_pronto or resp_valido.
// -----------------------------------------------------------------------------
module tb_agendador_conversor_bcd;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned LIM = 255;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valido;
    logic [N*W-1:0] req_dados;
    logic [N-1:0]   req_pronto;
    logic [N-1:0]   resp_valido;
    logic [15:0]    resp_bcd;
    logic           resp_erro;
    logic           core_iniciar;
    logic [W-1:0]   core_entrada;
    logic [15:0]    core_saida_bcd;
    logic           core_dados_validos;
    logic           ocupado;
    logic [15:0]    total_conversoes;

    agendador_conversor_bcd dut (
        .clk                (clk),
        .reset              (reset),
        .req_valido         (req_valido),
        .req_dados          (req_dados),
        .req_pronto         (req_pronto),
        .resp_valido        (resp_valido),
        .resp_bcd           (resp_bcd),
        .resp_erro          (resp_erro),
        .core_iniciar       (core_iniciar),
        .core_entrada       (core_entrada),
        .core_saida_bcd     (core_saida_bcd),
        .core_dados_validos (core_dados_validos),
        .ocupado            (ocupado),
        .total_conversoes   (total_conversoes)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int op;
    } grant_t;

    typedef struct {
        int          ch;
        logic [15:0] bcd;
        logic        erro;
        int          lat;
    } resp_t;

    grant_t exp_grant[$];
    resp_t  exp_resp[$];
    int     core_delay[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int model_prio = 0;
    int exp_total  = 0;
    int pronto_cyc = 0;
    int rd_ops[N];
    int rd_dl[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nome, act, exp, cyc);
    endtask

    task automatic falha(input string nome);
        n_chk++;
        $display("FAIL %s: bound expired at cycle %0d", nome, cyc);
    endtask

    // Decimal digits of v packed as 4-bit nibbles, least significant first
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            r[k*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Conversion core model: done pulse d cycles after the start cycle (0 = never)
    initial begin
        int          d;
        logic [15:0] v;
        core_dados_validos = 1'b0;
        core_saida_bcd     = '0;
        forever begin
            @(negedge clk);
            if (core_iniciar === 1'b1 && reset === 1'b0) begin
                v = to_bcd(int'(core_entrada));
                d = (core_delay.size() > 0) ? core_delay.pop_front() : 0;
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                    core_saida_bcd     = v;
                    core_dados_validos = 1'b1;
                    @(posedge clk);
                    #1;
                    core_dados_validos = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every grant and every response against the queues
    grant_t mg;
    resp_t  mr;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            exp_total = 0;
        end else begin
            if (req_pronto != '0) begin
                if (exp_grant.size() == 0) begin
                    chk("unexpected_req_pronto", 64'(req_pronto), 64'd0);
                end else begin
                    mg = exp_grant.pop_front();
                    chk("grant_channel", 64'(req_pronto), 64'(1) << mg.ch);
                    chk("core_iniciar_with_grant", 64'(core_iniciar), 64'd1);
                    chk("core_entrada", 64'(core_entrada), 64'(mg.op));
                    chk("ocupado_in_inicia", 64'(ocupado), 64'd1);
                    pronto_cyc = cyc;
                end
            end else if (core_iniciar !== 1'b0) begin
                chk("core_iniciar_without_grant", 64'(core_iniciar), 64'd0);
            end
            if (resp_valido != '0) begin
                if (exp_resp.size() == 0) begin
                    chk("unexpected_resp_valido", 64'(resp_valido), 64'd0);
                end else begin
                    mr = exp_resp.pop_front();
                    exp_total = (exp_total + 1) % 65536;
                    chk("resp_channel", 64'(resp_valido), 64'(1) << mr.ch);
                    chk("resp_bcd", 64'(resp_bcd), 64'(mr.bcd));
                    chk("resp_erro", 64'(resp_erro), 64'(mr.erro));
                    chk("resp_latency", 64'(cyc - pronto_cyc), 64'(mr.lat));
                    chk("total_conversoes", 64'(total_conversoes), 64'(exp_total));
                end
            end
        end
    end

    // Channels in mask request at once with rd_ops and hold until accepted.
    // rd_dl[k] is the core delay of the k-th grant of the round.
    task automatic run_round(input logic [N-1:0] mask);
        int           p, ch, k, budget, start;
        logic [N-1:0] rem;
        bit           first_seen;
        grant_t       g;
        resp_t        r;
        p   = model_prio;
        rem = mask;
        k   = 0;
        while (rem != '0) begin
            ch = p;
            while (!rem[ch]) ch = (ch + 1) % N;
            rem[ch] = 1'b0;
            g.ch = ch;
            g.op = rd_ops[ch];
            exp_grant.push_back(g);
            core_delay.push_back(rd_dl[k]);
            r.ch   = ch;
            r.erro = !(rd_dl[k] >= 1 && rd_dl[k] <= int'(LIM));
            r.bcd  = r.erro ? 16'h0000 : to_bcd(rd_ops[ch]);
            r.lat  = r.erro ? int'(LIM) + 1 : rd_dl[k] + 1;
            exp_resp.push_back(r);
            p = (ch + 1) % N;
            k++;
        end
        model_prio = p;

        for (int i = 0; i < N; i++) req_dados[i*W +: W] = W'(rd_ops[i]);
        req_valido = mask;
        start      = cyc;
        first_seen = 1'b0;
        budget     = 0;
        while ((req_valido != '0 || ocupado || exp_resp.size() != 0) && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
            if (!first_seen && req_pronto != '0) begin
                first_seen = 1'b1;
                chk("grant_latency", 64'(cyc - start), 64'd1);
            end
            req_valido = req_valido & ~req_pronto;
        end
        if (budget >= 2000) falha("round_timeout");
        chk("grants_drained", 64'(exp_grant.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_pronto"},   64'(req_pronto),       64'd0);
        chk({tag, "_resp_valido"},  64'(resp_valido),      64'd0);
        chk({tag, "_resp_bcd"},     64'(resp_bcd),         64'd0);
        chk({tag, "_resp_erro"},    64'(resp_erro),        64'd0);
        chk({tag, "_core_iniciar"}, 64'(core_iniciar),     64'd0);
        chk({tag, "_core_entrada"}, 64'(core_entrada),     64'd0);
        chk({tag, "_ocupado"},      64'(ocupado),          64'd0);
        chk({tag, "_total"},        64'(total_conversoes), 64'd0);
    endtask

    task automatic set_round(input int o0, o1, o2, o3, d0, d1, d2, d3);
        rd_ops[0] = o0; rd_ops[1] = o1; rd_ops[2] = o2; rd_ops[3] = o3;
        rd_dl[0]  = d0; rd_dl[1]  = d1; rd_dl[2]  = d2; rd_dl[3]  = d3;
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        int r;
        reset      = 1'b1;
        req_valido = '0;
        req_dados  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #1;

        // Single channel
        set_round(1234, 0, 0, 0, 4, 0, 0, 0);
        run_round(4'b0001);

        // Round robin over all channels, then channel 0 again
        set_round(1, 22, 333, 4444, 2, 7, 1, 12);
        run_round(4'b1111);
        set_round(1, 22, 333, 4444, 3, 0, 0, 0);
        run_round(4'b0001);

        // Pointer wrap: grant 2 moves the pointer to 3, then 0 before 2
        set_round(0, 0, 55, 0, 5, 0, 0, 0);
        run_round(4'b0100);
        set_round(606, 0, 707, 0, 6, 9, 0, 0);
        run_round(4'b0101);

        // Timeout: core never answers
        set_round(0, 0, 0, 5678, 0, 0, 0, 0);
        run_round(4'b1000);

        // Done pulse on the last allowed wait cycle wins over the timeout
        set_round(0, 9999, 0, 0, 255, 0, 0, 0);
        run_round(4'b0010);

        // Done pulses arriving during delivery or idle are ignored
        set_round(4321, 8765, 0, 0, 256, 257, 0, 0);
        run_round(4'b0011);

        // Reset while waiting for the core
        exp_grant.push_back('{ch: 1, op: 77});
        core_delay.push_back(0);
        req_dados[1*W +: W] = W'(77);
        req_valido = 4'b0010;
        budget = 0;
        while (req_pronto == '0 && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 20) falha("reset_test_grant");
        req_valido = '0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("mid_wait_reset");
        model_prio = 0;
        @(posedge clk);
        #1;
        // Pointer back at 0: channel 1 before channel 3
        set_round(0, 77, 0, 4321, 3, 5, 0, 0);
        run_round(4'b1010);

        // Randomized rounds
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < N; i++) begin
                rd_ops[i] = int'($urandom_range(0, 9999));
                r = int'($urandom_range(0, 19));
                if (r == 0)      rd_dl[i] = 0;
                else if (r == 1) rd_dl[i] = 255;
                else if (r == 2) rd_dl[i] = 254;
                else             rd_dl[i] = int'($urandom_range(1, 30));
            end
            run_round(N'($urandom_range(1, 15)));
        end

        chk("exp_grant_empty", 64'(exp_grant.size()), 64'd0);
        chk("exp_resp_empty",  64'(exp_resp.size()),  64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
